serial_subtractor: RTL and testbench

//  Bit-serial W-bit subtractor: computes diff = a - b LSB-first, one bit per clock,

---
 rtl/serial_subtractor.sv | 75 +++++++
 tb/tb_serial_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first W-bit subtractor; signed overflow output when SERIAL_SUB_OVF_EN is defined
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic bf, load, last, d, bf_nx;
    // Full-subtractor cell on the current LSBs, FSM next state and status decode
    always_comb begin
        load = start && (state != SHIFT);
        last = (state == SHIFT) && (cnt == CW'(W - 1));
        d = sa[0] ^ sb[0] ^ bf;
        bf_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf);
        busy = state == SHIFT;
        done = state == DONE;
        state_nx = load ? SHIFT : last ? DONE : (state == DONE) ? IDLE : state;
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // Operand shifters; the minuend register doubles as the result register, its vacated MSB taking each new difference bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
            bf <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sa <= a;
            sb <= b;
            bf <= 1'b0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sa <= {d, sa[W-1:1]};
            sb <= {1'b0, sb[W-1:1]};
            bf <= bf_nx;
            cnt <= cnt + CW'(1);
        end
    end
    // Visible results update only on the completion edge; on that edge sa[0]/sb[0] still hold the operand MSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= 1'b0;
`endif
        end else if (last) begin
            diff <= {d, sa[W-1:1]};
            borrow <= bf_nx;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= (sa[0] ^ sb[0]) & (sa[0] ^ d);
`endif
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven and scoreboard checks of serial_subtractor at W=8, exhaustive at W=4
module tb_serial_subtractor;
    logic clk = 1'b0, rst_n = 1'b1, start8 = 1'b0, start4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic busy8, done8, borrow8, busy4, done4, borrow4;
`ifdef SERIAL_SUB_OVF_EN
    logic ovf8, ovf4;
`endif
    int checks = 0, failures = 0;
    typedef struct {
        logic [7:0] a, b, diff;
        logic borrow, ovf;
    } vec_t;
    vec_t vecs[6];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.W(8)) dut8 (
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf8),
`endif
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.W(4)) dut4 (
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf4),
`endif
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive8(input vec_t v);
        @(negedge clk);
        a8 = v.a;
        b8 = v.b;
        start8 = 1'b1;
        exp_q.push_back(v);
    endtask

    // Called at the first negedge after acceptance; counts negedges (from the start-driving one) until done
    task automatic wait8(input logic [7:0] hold, output int cyc, output int nbusy, output bit held);
        cyc = 1;
        nbusy = 0;
        held = 1'b1;
        while (!done8 && cyc < 40) begin
            if (busy8) nbusy++;
            if (diff8 !== hold) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop_check(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_done"}, done8, 1);
            chk({tag, "_diff"}, diff8, e.diff);
            chk({tag, "_borrow"}, borrow8, e.borrow);
`ifdef SERIAL_SUB_OVF_EN
            chk({tag, "_ovf"}, ovf8, e.ovf);
`endif
        end
    endtask

    task automatic op8(input vec_t v, input string tag);
        int cyc, nbusy;
        bit held;
        logic [7:0] prev;
        prev = diff8;
        drive8(v);
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~v.a;
        b8 = ~v.b;
        wait8(prev, cyc, nbusy, held);
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_busy_span"}, nbusy, 8);
        chk({tag, "_prev_held"}, held, 1);
        pop_check(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done8, 0);
        chk({tag, "_idle_busy"}, busy8, 0);
    endtask

    initial begin
        int cyc, nbusy, n;
        bit held;
        vec_t v;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", borrow8, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) op8(vecs[i], $sformatf("vec%0d", i));

        // start held high with changing operands while busy: no re-sampling
        v = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        drive8(v);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        n = 4;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("held_start_latency", n, 9);
        pop_check("held_start");

        // back-to-back: reload in DONE, first result held until second completion
        @(negedge clk);
        drive8('{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1});
        @(negedge clk);
        start8 = 1'b0;
        wait8(8'h02, cyc, nbusy, held);
        pop_check("b2b_first");
        a8 = 8'h7F;
        b8 = 8'hFF;
        start8 = 1'b1;
        exp_q.push_back('{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1});
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_reload_busy", busy8, 1);
        wait8(8'h7F, cyc, nbusy, held);
        chk("b2b_gap", cyc, 9);
        chk("b2b_first_held", held, 1);
        pop_check("b2b_second");
        @(negedge clk);

        // reset in the middle of an operation aborts it
        drive8('{8'h55, 8'h2A, 8'h2B, 1'b0, 1'b0});
        repeat (5) @(negedge clk) start8 = 1'b0;
        chk("mid_busy_pre", busy8, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_diff", diff8, 0);
        chk("mid_rst_borrow", borrow8, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("mid_rst_ovf", ovf8, 0);
`endif
        exp_q.delete();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0) n++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0) n++;
        end
        chk("mid_rst_no_done", n, 0);
        op8('{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0}, "post_rst");
        op8('{8'hC8, 8'h64, 8'h64, 1'b0, 1'b1}, "post_rst2");

        // W=4 exhaustive
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                @(negedge clk);
                a4 = 4'(ai);
                b4 = 4'(bi);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                n = 1;
                while (!done4 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk($sformatf("w4_%0d_%0d", ai, bi), {n[7:0], 3'b0, borrow4, diff4},
                    {8'd5, 3'b0, (ai < bi) ? 1'b1 : 1'b0, 4'(ai - bi)});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
